// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises ibus/dbus transactions onto one memory port, dbus priority with ibus starvation guard
module mem_bus_arbiter #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                MASK_W     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ibus_req,
    input  logic              ibus_we,
    input  logic [ADDR_W-1:0] ibus_addr,
    input  logic [DATA_W-1:0] ibus_wdata,
    input  logic [MASK_W-1:0] ibus_mask,
    output logic [DATA_W-1:0] ibus_rdata,
    output logic              ibus_ready,
    input  logic              dbus_req,
    input  logic              dbus_we,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_wdata,
    input  logic [MASK_W-1:0] dbus_mask,
    output logic [DATA_W-1:0] dbus_rdata,
    output logic              dbus_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] starve_cnt;
    logic          owner_d;
    logic          sel_d;
    logic          start;
    logic          cap;

    assign sel_d = dbus_req && !(ibus_req && starve_cnt == SMAX);
    assign start = state == IDLE && (ibus_req || dbus_req);
    assign cap   = state_nx == DONE;

    // state register, aborts to IDLE on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next-state: one transaction walks IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (ibus_req || dbus_req) ? ISSUE : IDLE;
            ISSUE:   state_nx = !mem_gnt ? ISSUE : (mem_rvalid ? DONE : WAIT);
            WAIT:    state_nx = mem_rvalid ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // latched request fields, registered handshakes, read data capture and starvation count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            ibus_ready <= 1'b0;
            dbus_ready <= 1'b0;
            ibus_rdata <= '0;
            dbus_rdata <= '0;
        end else begin
            mem_req    <= state_nx == ISSUE;
            ibus_ready <= cap && !owner_d;
            dbus_ready <= cap && owner_d;
            if (start) begin
                owner_d    <= sel_d;
                mem_we     <= sel_d ? dbus_we : ibus_we;
                mem_addr   <= (sel_d ? dbus_addr : ibus_addr) - BASE_ADDR;
                mem_wdata  <= sel_d ? dbus_wdata : ibus_wdata;
                mem_mask   <= sel_d ? dbus_mask : ibus_mask;
                starve_cnt <= sel_d ? starve_cnt + CW'(ibus_req && starve_cnt != SMAX) : '0;
            end
            if (cap && !mem_we && !owner_d) ibus_rdata <= mem_rdata;
            if (cap && !mem_we && owner_d)  dbus_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table plus hand-written sequences for the arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ibus_req = 1'b0, ibus_we = 1'b0, dbus_req = 1'b0, dbus_we = 1'b0;
    logic [31:0] ibus_addr = '0, ibus_wdata = '0, dbus_addr = '0, dbus_wdata = '0;
    logic [3:0]  ibus_mask = '0, dbus_mask = '0;
    logic [31:0] ibus_rdata, dbus_rdata;
    logic        ibus_ready, dbus_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          gd;
        int          rd;
        logic [31:0] mrd;
        logic [31:0] eaddr;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    vec_t vt[6];

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_we(ibus_we), .ibus_addr(ibus_addr), .ibus_wdata(ibus_wdata),
        .ibus_mask(ibus_mask), .ibus_rdata(ibus_rdata), .ibus_ready(ibus_ready),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_mask(dbus_mask), .dbus_rdata(dbus_rdata), .dbus_ready(dbus_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " mem_req"}, {63'd0, mem_req}, 64'd0);
        chk({nm, " mem_fields"}, {mem_addr, mem_wdata}, 64'd0);
        chk({nm, " mem_we_mask"}, {59'd0, mem_we, mem_mask}, 64'd0);
        chk({nm, " ready"}, {62'd0, ibus_ready, dbus_ready}, 64'd0);
        chk({nm, " rdata"}, {ibus_rdata, dbus_rdata}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string s;
        s = $sformatf("v%0d", k);
        ibus_req = !v.d;
        dbus_req = v.d;
        if (v.d) begin
            dbus_we = v.we; dbus_addr = v.addr; dbus_wdata = v.wdata; dbus_mask = v.mask;
        end else begin
            ibus_we = v.we; ibus_addr = v.addr; ibus_wdata = v.wdata; ibus_mask = v.mask;
        end
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        chk({s, " issue mem_req"}, {63'd0, mem_req}, 64'd1);
        chk({s, " mem_addr"}, {32'd0, mem_addr}, {32'd0, v.eaddr});
        chk({s, " mem_we"}, {63'd0, mem_we}, {63'd0, v.we});
        chk({s, " mem_wdata"}, {32'd0, mem_wdata}, {32'd0, v.wdata});
        chk({s, " mem_mask"}, {60'd0, mem_mask}, {60'd0, v.mask});
        for (int i = 0; i < v.gd; i++) begin
            tick();
            chk({s, " hold"}, {27'd0, mem_req, mem_mask, mem_addr}, {27'd0, 1'b1, v.mask, v.eaddr});
        end
        mem_gnt = 1'b1;
        mem_rvalid = v.rd == 0;
        if (v.rd == 0) mem_rdata = v.mrd;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        chk({s, " mem_req after gnt"}, {63'd0, mem_req}, 64'd0);
        if (v.rd > 0) begin
            for (int i = 1; i < v.rd; i++) begin
                tick();
                chk({s, " no early ready"}, {62'd0, ibus_ready, dbus_ready}, 64'd0);
            end
            mem_rvalid = 1'b1;
            mem_rdata = v.mrd;
            tick();
            mem_rvalid = 1'b0;
        end
        chk({s, " ready"}, {62'd0, ibus_ready, dbus_ready}, {62'd0, !v.d, v.d});
        chk({s, " rdata"}, {ibus_rdata, dbus_rdata}, {v.eird, v.edrd});
        chk({s, " mem_addr stable"}, {32'd0, mem_addr}, {32'd0, v.eaddr});
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        tick();
        chk({s, " ready one cycle"}, {62'd0, ibus_ready, dbus_ready}, 64'd0);
    endtask

    initial begin
        logic [9:0] order;
        logic [9:0] exp_order;
        int         ng;
        //        d     we    addr           wdata          mask     gd rd mrd            eaddr          eird           edrd
        vt[0] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0,         4'b1111, 0, 0, 32'h0000_0013, 32'h0000_0010, 32'h0000_0013, 32'h0};
        vt[1] = '{1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 3, 1, 32'h7777_7777, 32'h0000_0100, 32'h0000_0013, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h8000_0200, 32'h0,         4'b1111, 1, 2, 32'hCAFE_F00D, 32'h0000_0200, 32'h0000_0013, 32'hCAFE_F00D};
        vt[3] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0BAD_CAFE, 4'b0000, 0, 0, 32'h6666_6666, 32'h8000_0004, 32'h0000_0013, 32'hCAFE_F00D};
        vt[4] = '{1'b1, 1'b1, 32'h8000_0300, 32'h0102_0304, 4'b1111, 0, 0, 32'h5555_5555, 32'h0000_0300, 32'h0000_0013, 32'hCAFE_F00D};
        vt[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'b1111, 2, 0, 32'h1234_5678, 32'h7FFF_FFFC, 32'h1234_5678, 32'hCAFE_F00D};

        tick();
        chk_zero("reset");
        rst = 1'b1;
        tick();
        chk("idle no req", {63'd0, mem_req}, 64'd0);

        for (int k = 0; k < 6; k++) run_vec(vt[k], k);

        // ibus drops req while waiting; a dbus request raised meanwhile is served afterwards
        ibus_req = 1'b1; ibus_we = 1'b0; ibus_addr = 32'h8000_0080;
        tick();
        chk("t5 ibus issue addr", {32'd0, mem_addr}, 64'h80);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        ibus_req = 1'b0;
        dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = 32'h8000_0090; dbus_wdata = 32'h1122_3344; dbus_mask = 4'hF;
        tick();
        chk("t5 no rearb in wait", {63'd0, mem_req}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        tick();
        mem_rvalid = 1'b0;
        chk("t5 ibus ready", {62'd0, ibus_ready, dbus_ready}, 64'b10);
        chk("t5 ibus rdata", {32'd0, ibus_rdata}, 64'hA5A5_A5A5);
        tick();
        chk("t5 idle", {61'd0, mem_req, ibus_ready, dbus_ready}, 64'd0);
        tick();
        chk("t5 dbus issue", {31'd0, mem_req, mem_we, mem_addr}, {31'd0, 1'b1, 1'b1, 32'h90});
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        dbus_req = 1'b0;
        chk("t5 dbus ready", {62'd0, ibus_ready, dbus_ready}, 64'b01);
        chk("t5 rdata kept", {ibus_rdata, dbus_rdata}, {32'hA5A5_A5A5, 32'hCAFE_F00D});
        tick();

        // reset while in WAIT clears everything at once; a late rvalid is then ignored
        ibus_req = 1'b1; ibus_we = 1'b0; ibus_addr = 32'h8000_0040;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2 rst = 1'b0;
        #1 chk_zero("t4 async reset");
        @(negedge clk);
        rst = 1'b1;
        ibus_req = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
        tick();
        mem_rvalid = 1'b0;
        chk("t4 late rvalid ignored", {61'd0, mem_req, ibus_ready, dbus_ready}, 64'd0);
        chk("t4 rdata stays 0", {ibus_rdata, dbus_rdata}, 64'd0);
        tick();
        chk("t4 still quiet", {61'd0, mem_req, ibus_ready, dbus_ready}, 64'd0);

        // both buses request continuously: dbus wins four times, then ibus once
        do_reset();
        ibus_req = 1'b1; ibus_we = 1'b0; ibus_addr = 32'h8000_1000;
        dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h8000_2000;
        exp_order = 10'b01111_01111;
        order = '0;
        ng = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            tick();
            if (ibus_ready || dbus_ready) begin
                order[ng] = dbus_ready;
                ng++;
            end
            mem_gnt = mem_req;
            mem_rvalid = mem_req;
        end
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        chk("t3 grant count", 64'(ng), 64'd10);
        for (int g = 0; g < 10; g++) chk($sformatf("t3 grant %0d dbus", g), {63'd0, order[g]}, {63'd0, exp_order[g]});
        tick();
        tick();
        chk("t3 drained", {61'd0, mem_req, ibus_ready, dbus_ready}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
